fnd_capture: RTL and testbench

Receive-side monitor for the two-digit multiplexed seven-segment (FND) interface. Watches the digit-select and segment lines driven by the FND driver, waits for each digit to settle, decodes the glyph back to a nibble, and rebuilds the 8-bit value, interpreting the digits as hex or decimal. Sits beside the FND driver in the IP as a loopback and self-check path, and is reused by benches as a scoreboard front end.

---
 rtl/fnd_pkg.sv | 21 ++
 rtl/fnd_glyph_decode.sv | 21 ++
 rtl/fnd_capture.sv | 156 +++++++++++++++
 tb/tb_fnd_capture.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the seven-segment (FND) driver and its capture monitor.
// Glyph table is indexed by nibble value, segment a in bit 0.
package fnd_pkg;

    localparam int NUM_GLYPHS = 16;

    localparam logic [6:0] GLYPH_TBL [NUM_GLYPHS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HAVE_LO = 2'd1,
        ST_HAVE_HI = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fnd_glyph_decode.sv
// Combinational glyph-to-nibble decoder; anything outside the 16-entry table
// (blank included) reports o_valid=0.
module fnd_glyph_decode (
    input  logic [6:0] i_seg,
    output logic       o_valid,
    output logic [3:0] o_nibble
);
    import fnd_pkg::*;

    always_comb begin
        o_valid  = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < NUM_GLYPHS; i++) begin
            if (i_seg == GLYPH_TBL[i]) begin
                o_valid  = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/fnd_capture.sv
// Receive-side monitor for a two-digit multiplexed FND bus: debounces each
// digit phase, decodes the glyph and rebuilds the 8-bit value (hex or decimal).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SYNC    | waiting for the first low-digit sample of a frame
// ST_HAVE_LO | low digit held, next high-digit sample completes the frame
// ST_HAVE_HI | frame just completed, waiting for the next low digit
module fnd_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       iCLK,
    input  logic       inReset,
    input  logic       iMode,
    input  logic       iSel,
    input  logic [6:0] iSeg,
    output logic [7:0] oHex,
    output logic       oValid,
    output logic       oChanged,
    output logic       oErr,
    output logic       oStall
);
    import fnd_pkg::*;

    localparam int STW = $clog2(STABLE_CYCLES);
    localparam int IDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STW-1:0] STABLE_MAX = STW'(STABLE_CYCLES - 1);
    localparam logic [IDW-1:0] IDLE_MAX   = IDW'(TIMEOUT_CYCLES);
    localparam logic [IDW-1:0] IDLE_ARM   = IDW'(TIMEOUT_CYCLES - 1);

    logic           r_sel;
    logic [6:0]     r_seg;
    logic           r_mode;
    logic [STW-1:0] r_stab;
    logic           r_taken;
    logic [IDW-1:0] r_idle;
    logic           r_stall;
    logic [3:0]     r_lo;
    logic [7:0]     r_hex;
    logic           r_valid;
    logic           r_changed;
    logic           r_err;
    logic           r_first;
    fsm_state_t     r_state;

    logic [6:0] w_seg_fix;
    logic       w_in_chg;
    logic       w_sel_chg;
    logic       w_mode_chg;
    logic       w_fire;
    logic       w_dig_ok;
    logic [3:0] w_dig;
    logic       w_dig_good;
    logic [7:0] w_frame;

    assign w_seg_fix  = SEG_ACTIVE_LOW ? ~iSeg : iSeg;
    assign w_in_chg   = {iSel, w_seg_fix} != {r_sel, r_seg};
    assign w_sel_chg  = iSel != r_sel;
    assign w_mode_chg = iMode != r_mode;
    assign w_fire     = (r_stab == STABLE_MAX) && !r_taken;

    fnd_glyph_decode u_decode (
        .i_seg    (r_seg),
        .o_valid  (w_dig_ok),
        .o_nibble (w_dig)
    );

    assign w_dig_good = w_dig_ok && (r_mode || (w_dig <= 4'd9));
    // Decimal: hi*10 + lo as (hi<<3) + (hi<<1) + lo, no multiplier needed.
    assign w_frame = r_mode ? {w_dig, r_lo}
                            : ({1'b0, w_dig, 3'b000} + {3'b000, w_dig, 1'b0} + {4'h0, r_lo});

    always_ff @(posedge iCLK) begin
        if (inReset) begin
            r_sel     <= 1'b0;
            r_seg     <= 7'h00;
            r_mode    <= 1'b0;
            r_stab    <= '0;
            r_taken   <= 1'b0;
            r_idle    <= '0;
            r_stall   <= 1'b0;
            r_lo      <= 4'h0;
            r_hex     <= 8'h00;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_err     <= 1'b0;
            r_first   <= 1'b1;
            r_state   <= ST_SYNC;
        end else begin
            r_sel  <= iSel;
            r_seg  <= w_seg_fix;
            r_mode <= iMode;

            if (w_in_chg)
                r_stab <= '0;
            else if (r_stab != STABLE_MAX)
                r_stab <= r_stab + STW'(1);

            if (w_sel_chg)
                r_taken <= 1'b0;
            else if (w_fire)
                r_taken <= 1'b1;

            if (w_sel_chg)
                r_idle <= '0;
            else if (r_idle != IDLE_MAX)
                r_idle <= r_idle + IDW'(1);
            r_stall <= !w_sel_chg && (r_idle >= IDLE_ARM);

            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            if (w_fire && !w_dig_good)
                r_err <= 1'b1;

            if (w_mode_chg || (w_fire && !w_dig_good)) begin
                r_state <= ST_SYNC;
            end else if (w_fire) begin
                case (r_state)
                    ST_SYNC: begin
                        if (r_sel == SEL_LO) begin
                            r_lo    <= w_dig;
                            r_state <= ST_HAVE_LO;
                        end
                    end
                    ST_HAVE_LO: begin
                        if (r_sel == SEL_HI) begin
                            r_hex     <= w_frame;
                            r_valid   <= 1'b1;
                            r_changed <= r_first || (w_frame != r_hex);
                            r_first   <= 1'b0;
                            r_state   <= ST_HAVE_HI;
                        end else begin
                            r_lo <= w_dig;
                        end
                    end
                    ST_HAVE_HI: begin
                        if (r_sel == SEL_LO) begin
                            r_lo    <= w_dig;
                            r_state <= ST_HAVE_LO;
                        end
                    end
                    default: r_state <= ST_SYNC;
                endcase
            end
        end
    end

    assign oHex     = r_hex;
    assign oValid   = r_valid;
    assign oChanged = r_changed;
    assign oErr     = r_err;
    assign oStall   = r_stall;

endmodule

// File: tb/tb_fnd_capture.sv
// Bench for fnd_capture: directed frames plus random frames, every cycle
// checked against a run-length / pending-sample reference model.
module tb_fnd_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 1024;

    localparam logic [6:0] TB_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       iCLK;
    logic       inReset;
    logic       iMode;
    logic       iSel;
    logic [6:0] iSeg;
    logic [7:0] oHex;
    logic       oValid;
    logic       oChanged;
    logic       oErr;
    logic       oStall;

    fnd_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .iCLK     (iCLK),
        .inReset  (inReset),
        .iMode    (iMode),
        .iSel     (iSel),
        .iSeg     (iSeg),
        .oHex     (oHex),
        .oValid   (oValid),
        .oChanged (oChanged),
        .oErr     (oErr),
        .oStall   (oStall)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_valid_cnt   = 0;
    int dut_changed_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit tb_decode(input logic [6:0] g, output logic [3:0] d);
        d = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (g == TB_GLYPH[i]) begin
                d = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Reference model: a digit is taken the first time its value has been seen on
    // STABLE consecutive edges within a select phase; it acts on the following edge.
    bit         m_init = 1'b0;
    logic       m_prev_sel, m_prev_mode;
    logic [6:0] m_prev_seg;
    int         m_run, m_idle;
    bit         m_taken, m_pend, m_lo_ok, m_first;
    logic       p_sel, p_mode;
    logic [6:0] p_seg;
    logic [3:0] m_lo;
    logic [7:0] m_hex;
    bit         m_valid, m_changed, m_err, m_stall;

    logic       c_rst, c_sel, c_mode;
    logic [6:0] c_seg;

    task automatic model_step();
        bit         mode_chg, ok, good;
        logic [3:0] d;
        int         v;
        if (c_rst) begin
            m_init = 1'b1;
            m_prev_sel = 1'b0; m_prev_seg = 7'h00; m_prev_mode = 1'b0;
            m_run = 1; m_taken = 1'b0; m_pend = 1'b0; m_lo_ok = 1'b0; m_lo = 4'h0;
            m_hex = 8'h00; m_valid = 1'b0; m_changed = 1'b0; m_err = 1'b0;
            m_first = 1'b1; m_idle = 0; m_stall = 1'b0;
        end else if (m_init) begin
            m_valid   = 1'b0;
            m_changed = 1'b0;
            mode_chg  = (c_mode != m_prev_mode);
            if (m_pend) begin
                ok   = tb_decode(p_seg, d);
                good = ok && (p_mode || (d <= 4'd9));
                if (!good) begin
                    m_err = 1'b1;
                    m_lo_ok = 1'b0;
                end else if (mode_chg) begin
                    m_lo_ok = 1'b0;
                end else if (p_sel == 1'b0) begin
                    m_lo = d;
                    m_lo_ok = 1'b1;
                end else if (m_lo_ok) begin
                    v = p_mode ? (int'(d) * 16 + int'(m_lo)) : (int'(d) * 10 + int'(m_lo));
                    m_changed = m_first || (8'(v) != m_hex);
                    m_hex = 8'(v);
                    m_valid = 1'b1;
                    m_first = 1'b0;
                    m_lo_ok = 1'b0;
                end
                m_pend = 1'b0;
            end else if (mode_chg) begin
                m_lo_ok = 1'b0;
            end

            if (c_sel == m_prev_sel && c_seg == m_prev_seg)
                m_run = (m_run < STABLE) ? m_run + 1 : STABLE;
            else
                m_run = 1;
            if (c_sel != m_prev_sel)
                m_taken = 1'b0;
            if (m_run >= STABLE && !m_taken) begin
                m_pend = 1'b1;
                m_taken = 1'b1;
                p_sel = c_sel; p_seg = c_seg; p_mode = c_mode;
            end

            if (c_sel != m_prev_sel)
                m_idle = 0;
            else if (m_idle < TIMEOUT)
                m_idle++;
            m_stall = (m_idle >= TIMEOUT);

            m_prev_sel = c_sel; m_prev_seg = c_seg; m_prev_mode = c_mode;
        end
    endtask

    always begin
        @(posedge iCLK);
        c_rst = inReset; c_sel = iSel; c_seg = iSeg; c_mode = iMode;
        @(negedge iCLK);
        model_step();
        if (m_init) begin
            chk("oHex",     32'(oHex),     32'(m_hex));
            chk("oValid",   32'(oValid),   32'(m_valid));
            chk("oChanged", 32'(oChanged), 32'(m_changed));
            chk("oErr",     32'(oErr),     32'(m_err));
            chk("oStall",   32'(oStall),   32'(m_stall));
            dut_valid_cnt   += int'(oValid);
            dut_changed_cnt += int'(oChanged);
        end
    end

    task automatic drive(input logic s, input logic [6:0] g, input logic m, input int n);
        iSel = s; iSeg = g; iMode = m;
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    int v0, c0;

    initial begin
        iSel = 1'b0; iSeg = 7'h3F; iMode = 1'b1; inReset = 1'b1;
        repeat (3) begin @(posedge iCLK); #1; end
        chk("rst_hex",   32'(oHex),   32'h00);
        chk("rst_valid", 32'(oValid), 32'h0);
        chk("rst_err",   32'(oErr),   32'h0);
        chk("rst_stall", 32'(oStall), 32'h0);
        inReset = 1'b0;

        // hex 0x13
        v0 = dut_valid_cnt; c0 = dut_changed_cnt;
        drive(1'b0, 7'h4F, 1'b1, 8);
        drive(1'b1, 7'h06, 1'b1, 8);
        chk("hex13_val",     32'(oHex), 32'h13);
        chk("hex13_valid_n", 32'(dut_valid_cnt - v0),   32'd1);
        chk("hex13_chg_n",   32'(dut_changed_cnt - c0), 32'd1);

        // decimal 19, then the same frame again
        drive(1'b0, 7'h6F, 1'b0, 8);
        drive(1'b1, 7'h06, 1'b0, 8);
        chk("dec19_val", 32'(oHex), 32'h13);
        v0 = dut_valid_cnt; c0 = dut_changed_cnt;
        drive(1'b0, 7'h6F, 1'b0, 8);
        drive(1'b1, 7'h06, 1'b0, 8);
        chk("dec19_rep_valid_n", 32'(dut_valid_cnt - v0),   32'd1);
        chk("dec19_rep_chg_n",   32'(dut_changed_cnt - c0), 32'd0);

        // short glitch to 8 inside the low phase must not be sampled
        v0 = dut_valid_cnt;
        drive(1'b0, 7'h4F, 1'b1, 2);
        drive(1'b0, 7'h7F, 1'b1, 2);
        drive(1'b0, 7'h4F, 1'b1, 8);
        drive(1'b1, 7'h06, 1'b1, 8);
        chk("glitch_val",     32'(oHex), 32'h13);
        chk("glitch_valid_n", 32'(dut_valid_cnt - v0), 32'd1);

        for (int f = 0; f < 25; f++) begin
            logic m;
            int   lo, hi;
            m  = 1'($urandom_range(0, 1));
            lo = m ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            hi = m ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, TB_GLYPH[$urandom_range(0, 15)], m, int'($urandom_range(1, 3)));
            drive(1'b0, TB_GLYPH[lo], m, int'($urandom_range(4, 9)));
            drive(1'b1, TB_GLYPH[hi], m, int'($urandom_range(3, 9)));
        end
        chk("rand_err", 32'(oErr), 32'h0);

        // blank glyph is invalid and sticky
        v0 = dut_valid_cnt;
        drive(1'b0, 7'h00, 1'b1, 8);
        chk("inv_err",     32'(oErr), 32'h1);
        drive(1'b1, 7'h06, 1'b1, 8);
        chk("inv_valid_n", 32'(dut_valid_cnt - v0), 32'd0);
        drive(1'b0, 7'h77, 1'b1, 8);
        drive(1'b1, 7'h6D, 1'b1, 8);
        chk("inv_after_val", 32'(oHex), 32'h5A);
        chk("inv_err_stick", 32'(oErr), 32'h1);

        // stall
        drive(1'b0, 7'h3F, 1'b1, 1100);
        chk("stall_on", 32'(oStall), 32'h1);
        drive(1'b1, 7'h06, 1'b1, 1);
        chk("stall_off", 32'(oStall), 32'h0);
        drive(1'b1, 7'h06, 1'b1, 7);
        chk("stall_frame", 32'(oHex), 32'h10);

        // reset mid-frame
        drive(1'b0, 7'h4F, 1'b1, 6);
        inReset = 1'b1;
        drive(1'b0, 7'h4F, 1'b1, 2);
        chk("mid_rst_hex",   32'(oHex),     32'h00);
        chk("mid_rst_valid", 32'(oValid),   32'h0);
        chk("mid_rst_chg",   32'(oChanged), 32'h0);
        chk("mid_rst_err",   32'(oErr),     32'h0);
        chk("mid_rst_stall", 32'(oStall),   32'h0);
        inReset = 1'b0;
        c0 = dut_changed_cnt;
        drive(1'b0, 7'h4F, 1'b1, 8);
        drive(1'b1, 7'h06, 1'b1, 8);
        chk("post_rst_val",   32'(oHex), 32'h13);
        chk("post_rst_chg_n", 32'(dut_changed_cnt - c0), 32'd1);
        chk("post_rst_err",   32'(oErr), 32'h0);

        // decimal mode rejects a hex-only digit
        v0 = dut_valid_cnt;
        drive(1'b0, 7'h3F, 1'b0, 8);
        drive(1'b1, 7'h77, 1'b0, 8);
        chk("decA_err",     32'(oErr), 32'h1);
        chk("decA_valid_n", 32'(dut_valid_cnt - v0), 32'd0);
        chk("decA_hex",     32'(oHex), 32'h13);

        drive(1'b1, 7'h77, 1'b0, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
